// File: rtl/swervolf_io_pkg.sv
// Shared types and constants for the SweRVolf board I/O conditioner.
package swervolf_io_pkg;

  localparam int DB_CNT_W  = 8;
  // Wide enough to hold any legal source index and UART_CH itself (max 8).
  localparam int SEL_MAX_W = 4;

  typedef logic [SEL_MAX_W-1:0] sel_t;

  typedef enum logic {
    IDLE_WAIT = 1'b0,
    SWITCH    = 1'b1
  } sel_state_e;

  function automatic int sel_width(input int ch);
    return (ch <= 1) ? 1 : $clog2(ch);
  endfunction

endpackage

// File: rtl/swervolf_debounce.sv
// One switch bit: 2-flop synchroniser, tick-driven persistence counter and level flip.
module swervolf_debounce
  import swervolf_io_pkg::*;
#(
  parameter int DB_COUNT = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sw,
  input  logic i_tick,
  output logic o_sw,
  output logic o_flip
);

  localparam logic [DB_CNT_W-1:0] LAST = DB_CNT_W'(DB_COUNT - 1);

  logic                r_s1;
  logic                r_s2;
  logic [DB_CNT_W-1:0] r_dc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_dc   <= '0;
      o_sw   <= 1'b0;
      o_flip <= 1'b0;
    end else begin
      r_s1   <= i_sw;
      r_s2   <= r_s1;
      o_flip <= 1'b0;
      // Any return to the accepted level restarts the persistence count.
      if (r_s2 == o_sw) begin
        r_dc <= '0;
      end else if (i_tick) begin
        if (r_dc == LAST) begin
          o_sw   <= ~o_sw;
          o_flip <= 1'b1;
          r_dc   <= '0;
        end else begin
          r_dc <= r_dc + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/swervolf_board_io.sv
// Board pin conditioner: debounced switches with edge interrupts, registered LEDs,
// and a glitch-free switch-selected UART TX mux that only changes source on an idle line.
module swervolf_board_io
  import swervolf_io_pkg::*;
#(
  parameter  int SW_WIDTH  = 16,
  parameter  int LED_WIDTH = 16,
  parameter  int DB_TICK   = 1000,
  parameter  int DB_COUNT  = 8,
  parameter  int UART_CH   = 2,
  parameter  int SEL_LSB   = 0,
  parameter  int UART_IDLE = 16,
  localparam int SELW      = sel_width(UART_CH)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [SW_WIDTH-1:0]  i_sw,
  output logic [SW_WIDTH-1:0]  o_sw,
  input  logic [SW_WIDTH-1:0]  i_irq_mask,
  input  logic [SW_WIDTH-1:0]  i_irq_clr,
  output logic [SW_WIDTH-1:0]  o_irq_pend,
  output logic                 o_irq,
  input  logic [LED_WIDTH-1:0] i_led,
  output logic [LED_WIDTH-1:0] o_led,
  input  logic [UART_CH-1:0]   i_tx,
  output logic                 o_uart_tx,
  output logic [SELW-1:0]      o_uart_sel
);

  localparam int                PRE_W    = $clog2(DB_TICK);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(DB_TICK - 1);
  localparam int                IDLE_W   = $clog2(UART_IDLE + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(UART_IDLE);

  logic [PRE_W-1:0]     r_pre;
  logic                 r_tick;
  logic [SW_WIDTH-1:0]  w_flip;
  logic [LED_WIDTH-1:0] r_led;
  logic                 r_tx;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pre  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_pre  <= (r_pre == PRE_LAST) ? '0 : r_pre + 1'b1;
      r_tick <= (r_pre == PRE_LAST);
    end
  end

  for (genvar g = 0; g < SW_WIDTH; g++) begin : g_db
    swervolf_debounce #(
      .DB_COUNT (DB_COUNT)
    ) u_db (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_sw   (i_sw[g]),
      .i_tick (r_tick),
      .o_sw   (o_sw[g]),
      .o_flip (w_flip[g])
    );
  end

  // A flip landing in the same cycle as a clear keeps the bit pending.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_irq_pend <= '0;
      o_irq      <= 1'b0;
      r_led      <= '0;
      o_led      <= '0;
    end else begin
      o_irq_pend <= (o_irq_pend & ~i_irq_clr) | w_flip;
      o_irq      <= |(o_irq_pend & i_irq_mask);
      r_led      <= i_led;
      o_led      <= r_led;
    end
  end

  assign o_uart_tx = r_tx;

  if (UART_CH == 1) begin : g_single
    assign o_uart_sel = '0;

    always_ff @(posedge i_clk) begin
      if (i_rst) r_tx <= 1'b1;
      else       r_tx <= i_tx[0];
    end
  end else begin : g_multi
    logic [SELW-1:0]   w_req;
    logic              w_req_ok;
    logic [SELW-1:0]   r_sel;
    logic [SELW-1:0]   r_next;
    logic [IDLE_W-1:0] r_idle;
    sel_state_e        r_state;

    assign w_req      = o_sw[SEL_LSB +: SELW];
    assign w_req_ok   = sel_t'(w_req) < sel_t'(UART_CH);
    assign o_uart_sel = r_sel;

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_state <= IDLE_WAIT;
        r_sel   <= '0;
        r_next  <= '0;
        r_idle  <= '0;
        r_tx    <= 1'b1;
      end else begin
        r_tx <= i_tx[r_sel];
        case (r_state)
          IDLE_WAIT: begin
            if (!i_tx[r_sel])            r_idle <= '0;
            else if (r_idle != IDLE_MAX) r_idle <= r_idle + 1'b1;
            if (w_req_ok && (w_req != r_sel) && (r_idle == IDLE_MAX)) begin
              r_next  <= w_req;
              r_state <= SWITCH;
            end
          end
          SWITCH: begin
            r_sel   <= r_next;
            r_idle  <= '0;
            r_state <= IDLE_WAIT;
          end
          default: r_state <= IDLE_WAIT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_swervolf_board_io.sv
// Directed bench: two instances (2-source and 3-source UART mux) with a short debounce.
module tb_swervolf_board_io;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sw, sw_o, mask, clr, pend, led, led_o;
  logic        irq, uart_tx;
  logic [1:0]  tx;
  logic [0:0]  sel;
  logic [15:0] sw2, sw2_o, pend2, led2_o;
  logic        irq2, uart2_tx;
  logic [2:0]  tx2;
  logic [1:0]  sel2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  swervolf_board_io #(
    .SW_WIDTH (16), .LED_WIDTH (16), .DB_TICK (4), .DB_COUNT (3),
    .UART_CH (2), .SEL_LSB (4), .UART_IDLE (16)
  ) dut (
    .i_clk (clk), .i_rst (rst), .i_sw (sw), .o_sw (sw_o),
    .i_irq_mask (mask), .i_irq_clr (clr), .o_irq_pend (pend), .o_irq (irq),
    .i_led (led), .o_led (led_o), .i_tx (tx), .o_uart_tx (uart_tx), .o_uart_sel (sel)
  );

  swervolf_board_io #(
    .SW_WIDTH (16), .LED_WIDTH (16), .DB_TICK (4), .DB_COUNT (3),
    .UART_CH (3), .SEL_LSB (4), .UART_IDLE (16)
  ) dut3 (
    .i_clk (clk), .i_rst (rst), .i_sw (sw2), .o_sw (sw2_o),
    .i_irq_mask (16'h0000), .i_irq_clr (16'h0000), .o_irq_pend (pend2), .o_irq (irq2),
    .i_led (16'h0000), .o_led (led2_o), .i_tx (tx2), .o_uart_tx (uart2_tx), .o_uart_sel (sel2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_cmp++; if (sw_o !== 16'h0000) begin n_bad++; $display("FAIL rst_sw got %h want 0000", sw_o); end
    n_cmp++; if (pend !== 16'h0000) begin n_bad++; $display("FAIL rst_pend got %h want 0000", pend); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL rst_irq got %b want 0", irq); end
    n_cmp++; if (led_o !== 16'h0000) begin n_bad++; $display("FAIL rst_led got %h want 0000", led_o); end
    n_cmp++; if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL rst_tx got %b want 1", uart_tx); end
    n_cmp++; if (sel !== 1'b0) begin n_bad++; $display("FAIL rst_sel got %h want 0", sel); end
    n_cmp++; if (sel2 !== 2'd0) begin n_bad++; $display("FAIL rst_sel2 got %h want 0", sel2); end
    rst = 1'b0;
  endtask

  task automatic test_debounce();
    int n;
    mask = 16'h0001;
    sw   = 16'h0001;
    n = 0;
    while (n < 40 && sw_o[0] !== 1'b1) begin
      step();
      n++;
    end
    // 2 sync cycles plus (DB_COUNT-1)*DB_TICK+1 .. DB_COUNT*DB_TICK, with margin.
    n_cmp++; if (n < 11 || n > 16) begin n_bad++; $display("FAIL db_latency got %0d cycles want 11..16", n); end
    n_cmp++; if (pend !== 16'h0000) begin n_bad++; $display("FAIL db_pend_early got %h want 0000", pend); end
    step();
    n_cmp++; if (pend !== 16'h0001) begin n_bad++; $display("FAIL db_pend got %h want 0001", pend); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL db_irq_early got %b want 0", irq); end
    step();
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL db_irq got %b want 1", irq); end
  endtask

  task automatic test_bounce();
    int bad_sw = 0;
    int bad_pd = 0;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 10; c++) begin
        sw = (c < 5) ? 16'h0009 : 16'h0001;
        step();
        if (sw_o[3] !== 1'b0) bad_sw++;
        if (pend[3] !== 1'b0) bad_pd++;
      end
    end
    for (int c = 0; c < 6; c++) step();
    n_cmp++; if (bad_sw != 0) begin n_bad++; $display("FAIL bounce_sw got %0d bad cycles want 0", bad_sw); end
    n_cmp++; if (bad_pd != 0) begin n_bad++; $display("FAIL bounce_pend got %0d bad cycles want 0", bad_pd); end
    n_cmp++; if (sw_o !== 16'h0001) begin n_bad++; $display("FAIL bounce_swall got %h want 0001", sw_o); end
    n_cmp++; if (pend !== 16'h0001) begin n_bad++; $display("FAIL bounce_pendall got %h want 0001", pend); end
  endtask

  task automatic test_clr_vs_set();
    int n = 0;
    sw = 16'h0000;
    while (n < 40 && sw_o[0] !== 1'b0) begin
      step();
      n++;
    end
    n_cmp++; if (sw_o[0] !== 1'b0) begin n_bad++; $display("FAIL clr_fall got %b want 0", sw_o[0]); end
    clr = 16'h0001;
    step();
    clr = 16'h0000;
    n_cmp++; if (pend[0] !== 1'b1) begin n_bad++; $display("FAIL set_wins got %b want 1", pend[0]); end
    step();
    clr = 16'h0001;
    step();
    clr = 16'h0000;
    n_cmp++; if (pend !== 16'h0000) begin n_bad++; $display("FAIL clr_pend got %h want 0000", pend); end
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL clr_irq_lag got %b want 1", irq); end
    step();
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL clr_irq got %b want 0", irq); end
  endtask

  task automatic test_led();
    led = 16'hA5A5;
    step();
    n_cmp++; if (led_o !== 16'h0000) begin n_bad++; $display("FAIL led_lat1 got %h want 0000", led_o); end
    led = 16'h5A5A;
    step();
    n_cmp++; if (led_o !== 16'hA5A5) begin n_bad++; $display("FAIL led_a5 got %h want a5a5", led_o); end
    step();
    n_cmp++; if (led_o !== 16'h5A5A) begin n_bad++; $display("FAIL led_5a got %h want 5a5a", led_o); end
  endtask

  task automatic test_uart_switch();
    int bad_sel = 0;
    int bad_tx  = 0;
    int k = 0;
    sw = 16'h0010;
    tx = 2'b01;
    for (int c = 0; c < 64; c++) begin
      tx[0] = ((c % 8) != 7);
      step();
      if (uart_tx !== tx[0]) bad_tx++;
      if (sel !== 1'b0) bad_sel++;
    end
    n_cmp++; if (sw_o[4] !== 1'b1) begin n_bad++; $display("FAIL uart_req got %b want 1", sw_o[4]); end
    n_cmp++; if (bad_sel != 0) begin n_bad++; $display("FAIL uart_hold got %0d bad cycles want 0", bad_sel); end
    n_cmp++; if (bad_tx != 0) begin n_bad++; $display("FAIL uart_follow0 got %0d bad cycles want 0", bad_tx); end
    tx[0] = 1'b1;
    while (k < 40 && sel !== 1'b1) begin
      step();
      k++;
    end
    n_cmp++; if (k < 17 || k > 20) begin n_bad++; $display("FAIL uart_switch_time got %0d cycles want 17..20", k); end
    step();
    n_cmp++; if (uart_tx !== 1'b0) begin n_bad++; $display("FAIL uart_follow1_lo got %b want 0", uart_tx); end
    tx[1] = 1'b1;
    step();
    n_cmp++; if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL uart_follow1_hi got %b want 1", uart_tx); end
  endtask

  task automatic test_uart_invalid_req();
    int bad_sel = 0;
    int k = 0;
    sw2 = 16'h0030;
    for (int c = 0; c < 60; c++) begin
      step();
      if (sel2 !== 2'd0) bad_sel++;
    end
    n_cmp++; if (sw2_o[5:4] !== 2'd3) begin n_bad++; $display("FAIL inv_req got %h want 3", sw2_o[5:4]); end
    n_cmp++; if (bad_sel != 0) begin n_bad++; $display("FAIL inv_hold got %0d bad cycles want 0", bad_sel); end
    sw2 = 16'h0020;
    while (k < 60 && sel2 !== 2'd2) begin
      step();
      k++;
    end
    n_cmp++; if (sel2 !== 2'd2) begin n_bad++; $display("FAIL inv_then_valid got %h want 2", sel2); end
  endtask

  task automatic test_reset_mid();
    mask = 16'hFFFF;
    sw   = 16'h0000;
    tx   = 2'b00;
    for (int c = 0; c < 5; c++) step();
    n_cmp++; if (sw_o !== 16'h0010) begin n_bad++; $display("FAIL mid_pre_sw got %h want 0010", sw_o); end
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL mid_pre_irq got %b want 1", irq); end
    n_cmp++; if (uart_tx !== 1'b0) begin n_bad++; $display("FAIL mid_pre_tx got %b want 0", uart_tx); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (sw_o !== 16'h0000) begin n_bad++; $display("FAIL mid_sw got %h want 0000", sw_o); end
    n_cmp++; if (pend !== 16'h0000) begin n_bad++; $display("FAIL mid_pend got %h want 0000", pend); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL mid_irq got %b want 0", irq); end
    n_cmp++; if (led_o !== 16'h0000) begin n_bad++; $display("FAIL mid_led got %h want 0000", led_o); end
    n_cmp++; if (uart_tx !== 1'b1) begin n_bad++; $display("FAIL mid_tx got %b want 1", uart_tx); end
    n_cmp++; if (sel !== 1'b0) begin n_bad++; $display("FAIL mid_sel got %h want 0", sel); end
    n_cmp++; if (sel2 !== 2'd0) begin n_bad++; $display("FAIL mid_sel2 got %h want 0", sel2); end
  endtask

  initial begin
    rst  = 1'b1;
    sw   = '0;
    mask = '0;
    clr  = '0;
    led  = '0;
    tx   = 2'b11;
    sw2  = '0;
    tx2  = 3'b111;
    test_reset();
    test_debounce();
    test_bounce();
    test_clr_vs_set();
    test_led();
    test_uart_switch();
    test_uart_invalid_req();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
